// File: rtl/sel_decoder.sv
// rtl/sel_decoder.sv - registered code-to-one-hot select decoder with optional sweep FSM
//
// Optional feature: define SEL_DECODER_SWEEP_EN to build the IDLE/SWEEP/DONE
// sweep FSM and its counter. Without it, sweep_start is ignored, busy and
// sweep_done stay 0, and only the plain decode path exists.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   en           decode request for code
//   code         index to decode (CODE_W bits)
//   sweep_start  request a one-hot walk over all NUM_SEL selects
//   selection    registered one-hot select, or all-zero
//   sel_valid    selection holds a valid one-hot value
//   out_of_range last accepted code was >= NUM_SEL
//   busy         sweep in progress
//   sweep_done   one-cycle pulse after the last sweep select
module sel_decoder #(
  parameter int CODE_W  = 5,
  parameter int NUM_SEL = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [CODE_W-1:0]  code,
  input  logic               sweep_start,
  output logic [NUM_SEL-1:0] selection,
  output logic               sel_valid,
  output logic               out_of_range,
  output logic               busy,
  output logic               sweep_done
);

  function automatic logic [NUM_SEL-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [NUM_SEL-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      v[i] = (32'(idx) == i);
    end
    return v;
  endfunction

  // Plain decode of the current request; used directly from IDLE.
  logic               in_range;
  logic [NUM_SEL-1:0] dec_sel;
  logic               dec_valid;
  logic               dec_oor;

  assign in_range = (32'(code) < NUM_SEL);

  always_comb begin
    dec_sel   = '0;
    dec_valid = 1'b0;
    dec_oor   = 1'b0;
    if (en) begin
      if (in_range) begin
        dec_sel   = onehot(code);
        dec_valid = 1'b1;
      end else begin
        dec_oor = 1'b1;
      end
    end
  end

  // Next values of the output registers.
  logic [NUM_SEL-1:0] sel_nxt;
  logic               valid_nxt;
  logic               oor_nxt;
  logic               busy_nxt;
  logic               done_nxt;

`ifdef SEL_DECODER_SWEEP_EN

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] LAST = CODE_W'(NUM_SEL - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] cnt;
  logic [CODE_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = '0;
    valid_nxt = 1'b0;
    oor_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A sweep request beats a decode request in the same cycle.
        if (sweep_start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
          sel_nxt   = onehot('0);
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          sel_nxt   = dec_sel;
          valid_nxt = dec_valid;
          oor_nxt   = dec_oor;
        end
      end
      SWEEP: begin
        // en and sweep_start are deliberately not looked at here.
        if (cnt == LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CODE_W'(1);
          sel_nxt   = onehot(cnt + CODE_W'(1));
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`else

  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;

  always_comb begin
    sel_nxt   = dec_sel;
    valid_nxt = dec_valid;
    oor_nxt   = dec_oor;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      selection    <= '0;
      sel_valid    <= 1'b0;
      out_of_range <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      selection    <= sel_nxt;
      sel_valid    <= valid_nxt;
      out_of_range <= oor_nxt;
      busy         <= busy_nxt;
      sweep_done   <= done_nxt;
    end
  end

endmodule

// File: doc/sel_decoder.md
SEL_DECODER -- requirements
Module: sel_decoder

Interface
REQ-001 Parameter CODE_W, default 5, width of the input code.
REQ-002 Parameter NUM_SEL, default 32, number of select outputs; legal range 2..2**CODE_W.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port en, input, 1, decode request for the current code.
REQ-006 Port code, input, CODE_W, index to decode.
REQ-007 Port sweep_start, input, 1, request a one-hot walk over all selects.
REQ-008 Port selection, output, NUM_SEL, registered one-hot select (or all-zero).
REQ-009 Port sel_valid, output, 1, selection holds a valid one-hot value this cycle.
REQ-010 Port out_of_range, output, 1, last accepted code was >= NUM_SEL.
REQ-011 Port busy, output, 1, sweep in progress.
REQ-012 Port sweep_done, output, 1, one-cycle pulse ending a sweep.

Function
REQ-013 FSM states SHALL be IDLE, SWEEP, DONE; reset state IDLE.
REQ-014 IDLE, en=1, code<NUM_SEL: next cycle selection bit [code] only =1, sel_valid=1, out_of_range=0 (latency 1 clock).
REQ-015 IDLE, en=1, code>=NUM_SEL: next cycle selection=0, sel_valid=0, out_of_range=1.
REQ-016 IDLE, en=0, sweep_start=0: next cycle selection=0, sel_valid=0, out_of_range=0.
REQ-017 IDLE, sweep_start=1: next cycle state SWEEP, internal counter=0, selection bit 0=1, sel_valid=1, busy=1; en ignored that cycle (sweep wins).
REQ-018 SWEEP: each cycle counter increments by 1 and selection is one-hot of counter; sel_valid=1, busy=1, out_of_range=0.
REQ-019 SWEEP with counter=NUM_SEL-1: next cycle state DONE, selection=0, sel_valid=0, busy=0, sweep_done=1.
REQ-020 DONE: unconditionally to IDLE next cycle; sweep_done=0 afterwards; en/sweep_start in DONE ignored.
REQ-021 A sweep SHALL occupy exactly NUM_SEL cycles of busy=1 followed by one sweep_done cycle.
REQ-022 sweep_start and en while busy=1 SHALL be ignored (no restart, no extension).
REQ-023 Counter width SHALL be CODE_W; counter SHALL never exceed NUM_SEL-1 (no wrap to 0 within a sweep).
REQ-024 selection SHALL never have more than one bit set in any cycle.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, counter 0, selection 0, sel_valid 0, out_of_range 0, busy 0, sweep_done 0.
REQ-027 reset SHALL take priority over en and sweep_start in the same cycle.
REQ-028 reset asserted mid-sweep SHALL abort the sweep with no sweep_done pulse.

Configuration
REQ-029 Macro SEL_DECODER_SWEEP_EN SHALL compile the sweep FSM and counter in.
REQ-030 Defined: behaviour per REQ-013..REQ-023.
REQ-031 Undefined: sweep_start ignored, busy and sweep_done tied 0, state fixed IDLE; port list unchanged; REQ-014..REQ-016 still hold.

Verification
REQ-032 Defaults, reset 2 cycles, en=1, code=5'd0..5'd31 one per cycle -> each next cycle selection=32'h1<<code, sel_valid=1.
REQ-033 NUM_SEL=24, en=1, code=5'd24 -> next cycle selection=0, sel_valid=0, out_of_range=1; code=5'd23 -> selection=24'h800000, out_of_range=0.
REQ-034 Macro defined, defaults, sweep_start pulse with en=1 code=5'd7 -> selection 32'h1,32'h2,...,32'h80000000 over 32 cycles, busy=1 throughout, then sweep_done=1 one cycle, selection=0.
REQ-035 Macro defined, sweep_start re-pulsed at sweep cycle 10 -> sweep still ends after 32 busy cycles, single sweep_done.
REQ-036 Macro defined, reset at sweep cycle 5 -> next cycle all outputs 0, no sweep_done; en=1 code=5'd3 next -> selection=32'h8.
REQ-037 Macro undefined, sweep_start=1 en=1 code=5'd2 -> next cycle selection=32'h4, busy=0, sweep_done never 1.
